// File: rtl/od_line_arbiter_if.sv
// Bundle of requester-side and pad-side signals for the open-drain line arbiter.
// The arbiter uses the slave modport; requesters and the pad model use the master modport.
interface od_line_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] data;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic              err;
    logic              line_oe;
    logic              line_in;

    modport master (
        output req,
        output data,
        output line_in,
        input  gnt,
        input  busy,
        input  done,
        input  err,
        input  line_oe
    );

    modport slave (
        input  req,
        input  data,
        input  line_in,
        output gnt,
        output busy,
        output done,
        output err,
        output line_oe
    );
endinterface

// File: rtl/od_line_arbiter.sv
// Round-robin arbiter and MSB-first serializer for a shared open-drain line with readback.
// Optional feature macro ODLA_PARITY_EN appends an even-parity bit after bit 0.
module od_line_arbiter #(
    parameter int NREQ    = 4,
    parameter int BIT_CYC = 4,
    parameter int TA_CYC  = 2
) (
    input logic             clk,
    input logic             rst,
    od_line_arbiter_if.slave bus
);

`ifdef ODLA_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif
    localparam int IDX_W = $clog2(NREQ);
    localparam int CYC_W = $clog2(BIT_CYC);
    localparam int BIT_W = $clog2(NBITS);
    localparam int TA_W  = (TA_CYC > 1) ? $clog2(TA_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        TURN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cur_idx;
    logic [NBITS-1:0] shreg;
    logic [CYC_W-1:0] cyc_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [TA_W-1:0]  ta_cnt;
    logic [NREQ-1:0]  gnt_q;
    logic             busy_q;
    logic             line_oe_q;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [7:0]       pick_byte;
    logic [NBITS-1:0] load_bits;
    logic             mid_cyc;
    logic             last_cyc;
    logic             last_bit;
    logic             collision;
    logic [IDX_W-1:0] next_ptr;

    // First asserted request at or after the round-robin pointer, wrapping.
    always_comb begin
        int j;
        j          = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!pick_valid && bus.req[j]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

    assign pick_byte = bus.data[{pick_idx, 3'b000} +: 8];

`ifdef ODLA_PARITY_EN
    assign load_bits = {pick_byte, ^pick_byte};
`else
    assign load_bits = pick_byte;
`endif

    assign mid_cyc  = (cyc_cnt == CYC_W'(BIT_CYC / 2));
    assign last_cyc = (cyc_cnt == CYC_W'(BIT_CYC - 1));
    assign last_bit = (bit_cnt == BIT_W'(NBITS - 1));
    assign next_ptr = (cur_idx == IDX_W'(NREQ - 1)) ? '0 : cur_idx + 1'b1;

    // A released bit that reads back low means another driver owns the line.
    assign collision = (state == SEND) && mid_cyc && shreg[NBITS-1] && !bus.line_in;

    assign bus.err     = collision;
    assign bus.done    = (state == SEND) && last_cyc && last_bit && !collision;
    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.line_oe = line_oe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_idx   <= '0;
            shreg     <= '0;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            ta_cnt    <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            line_oe_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    line_oe_q <= 1'b0;
                    if (pick_valid) begin
                        state     <= SEND;
                        cur_idx   <= pick_idx;
                        gnt_q     <= NREQ'(1) << pick_idx;
                        busy_q    <= 1'b1;
                        shreg     <= load_bits;
                        line_oe_q <= ~load_bits[NBITS-1];
                        cyc_cnt   <= '0;
                        bit_cnt   <= '0;
                    end
                end

                SEND: begin
                    if (collision || (last_cyc && last_bit)) begin
                        state     <= TURN;
                        gnt_q     <= '0;
                        line_oe_q <= 1'b0;
                        rr_ptr    <= next_ptr;
                        ta_cnt    <= '0;
                    end else if (last_cyc) begin
                        cyc_cnt   <= '0;
                        bit_cnt   <= bit_cnt + 1'b1;
                        shreg     <= {shreg[NBITS-2:0], 1'b0};
                        line_oe_q <= ~shreg[NBITS-2];
                    end else begin
                        cyc_cnt   <= cyc_cnt + 1'b1;
                    end
                end

                TURN: begin
                    if (ta_cnt == TA_W'(TA_CYC - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        ta_cnt <= ta_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    gnt_q     <= '0;
                    busy_q    <= 1'b0;
                    line_oe_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_od_line_arbiter.sv
// Self-checking bench for od_line_arbiter: directed scenarios plus random transfers
// checked cycle by cycle against a bit-list model of the line and a round-robin pointer model.
module tb_od_line_arbiter;

    localparam int NREQ    = 4;
    localparam int BIT_CYC = 4;
    localparam int TA_CYC  = 2;
`ifdef ODLA_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic clk;
    logic rst;
    logic ext_low;
    int   n_checks;
    int   n_fail;
    int   rr_m;

    od_line_arbiter_if #(.NREQ(NREQ)) bus ();

    assign bus.line_in = ~bus.line_oe & ~ext_low;

    od_line_arbiter #(
        .NREQ   (NREQ),
        .BIT_CYC(BIT_CYC),
        .TA_CYC (TA_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Entered during an IDLE cycle with req/data already driven; leaves in the next IDLE cycle.
    task automatic apply_stimulus(input int low_bit, input bit mid_change);
        int         win;
        logic [7:0] byte_v;
        logic       bits [NBITS];
        bit         aborted;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (win < 0 && bus.req[(rr_m + k) % NREQ]) win = (rr_m + k) % NREQ;
        end
        if (win < 0) begin
            $display("[TB] apply_stimulus called with no request");
            return;
        end
        byte_v = bus.data[win*8 +: 8];
        for (int b = 0; b < 8; b++) bits[b] = byte_v[7-b];
`ifdef ODLA_PARITY_EN
        bits[8] = ^byte_v;
`endif
        check_output("idle_gnt", bus.gnt, 0);
        check_output("idle_busy", bus.busy, 0);
        tick();
        aborted = 0;
        for (int k = 0; k < NBITS*BIT_CYC && !aborted; k++) begin
            int   b;
            int   c;
            logic exp_oe;
            logic exp_err;
            logic exp_done;
            b = k / BIT_CYC;
            c = k % BIT_CYC;
            ext_low = (b == low_bit);
            #1;
            exp_oe   = ~bits[b];
            exp_err  = bits[b] && (b == low_bit) && (c == BIT_CYC/2);
            exp_done = (k == NBITS*BIT_CYC - 1) && !exp_err;
            check_output("send_gnt", bus.gnt, 1 << win);
            check_output("send_line_oe", bus.line_oe, exp_oe);
            check_output("send_busy", bus.busy, 1);
            check_output("send_err", bus.err, exp_err);
            check_output("send_done", bus.done, exp_done);
            if (mid_change && k == 3*BIT_CYC) begin
                bus.req[win] = 1'b0;
                bus.data[win*8 +: 8] = ~byte_v;
            end
            if (exp_err) aborted = 1;
            tick();
        end
        ext_low = 1'b0;
        rr_m = (win + 1) % NREQ;
        for (int t = 0; t < TA_CYC; t++) begin
            check_output("turn_gnt", bus.gnt, 0);
            check_output("turn_line_oe", bus.line_oe, 0);
            check_output("turn_busy", bus.busy, 1);
            check_output("turn_done", bus.done, 0);
            check_output("turn_err", bus.err, 0);
            tick();
        end
        check_output("back_idle_busy", bus.busy, 0);
        check_output("back_idle_line_oe", bus.line_oe, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rr_m     = 0;
        rst      = 1'b1;
        ext_low  = 1'b0;
        bus.req  = '0;
        bus.data = '0;
        tick();
        tick();
        tick();
        check_output("reset_gnt", bus.gnt, 0);
        check_output("reset_busy", bus.busy, 0);
        check_output("reset_line_oe", bus.line_oe, 0);
        check_output("reset_done", bus.done, 0);
        check_output("reset_err", bus.err, 0);
        rst = 1'b0;
        tick();

        $display("[TB] single request, requester 1, byte A5");
        bus.data[15:8] = 8'hA5;
        bus.req = 4'b0010;
        apply_stimulus(-1, 0);
        bus.req = '0;
        tick();

        $display("[TB] all requesters held from reset");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr_m = 0;
        tick();
        bus.data = 32'h3C_81_5A_C3;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) apply_stimulus(-1, 0);
        bus.req = '0;
        tick();

        $display("[TB] reset in the middle of bit 5");
        bus.data[31:24] = 8'h96;
        bus.req = 4'b1000;
        tick();
        check_output("abort_gnt_before", bus.gnt, 4'b1000);
        for (int i = 0; i < 5*BIT_CYC + 1; i++) tick();
        rst = 1'b1;
        tick();
        check_output("abort_gnt", bus.gnt, 0);
        check_output("abort_line_oe", bus.line_oe, 0);
        check_output("abort_busy", bus.busy, 0);
        check_output("abort_done", bus.done, 0);
        check_output("abort_err", bus.err, 0);
        rst = 1'b0;
        rr_m = 0;
        bus.data[7:0] = 8'h4E;
        bus.req = 4'b1001;
        apply_stimulus(-1, 0);
        bus.req = '0;
        tick();

        $display("[TB] collision on bit 3, requester 2, byte FF");
        bus.data[23:16] = 8'hFF;
        bus.req = 4'b0100;
        apply_stimulus(3, 0);
        bus.req = '0;
        tick();

        $display("[TB] request dropped and data changed mid-transfer");
        bus.data[7:0] = 8'hB2;
        bus.req = 4'b0001;
        apply_stimulus(-1, 1);
        bus.req = '0;
        tick();

`ifdef ODLA_PARITY_EN
        $display("[TB] parity transfer, byte 07");
        bus.data[7:0] = 8'h07;
        bus.req = 4'b0001;
        apply_stimulus(-1, 0);
        bus.req = '0;
        tick();
`endif

        $display("[TB] random transfers");
        for (int i = 0; i < 16; i++) begin
            bus.data = $urandom;
            bus.req  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            apply_stimulus(int'($urandom_range(0, NBITS + 3)), bit'($urandom_range(0, 1)));
        end
        bus.req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
